limit_debounce: RTL and testbench
=================================

LIMIT_DEBOUNCE -- requirements
Module: limit_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of limit-switch channels.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer flop count, legal range 2..4.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), stable-level qualification time, legal value >= 1.
REQ-004 SHALL provide parameter ACTIVE_LOW, default 1; 1 = raw pin low means switch engaged.
REQ-005 SHALL provide port clk, input, 1, system clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset, input, 1; the reset is synchronous and active-high.
REQ-007 SHALL provide port sw_raw, input, WIDTH, asynchronous raw limit-switch pins.
REQ-008 SHALL provide port trip_clr, input, WIDTH, per-bit clear of the trip latch, sampled on clk.
REQ-009 SHALL provide port limit_out, output, WIDTH, debounced level, 1 = engaged; drives the limit PIO in_port.
REQ-010 SHALL provide port limit_rise, output, WIDTH, one-cycle pulse per bit on a debounced engage.
REQ-011 SHALL provide port limit_fall, output, WIDTH, one-cycle pulse per bit on a debounced release.
REQ-012 SHALL provide port trip, output, WIDTH, sticky per-bit engage latch.
REQ-013 SHALL provide port any_limit, output, 1, OR-reduction of limit_out.

Function
REQ-014 Each bit SHALL pass through a chain of SYNC_STAGES flops; after the polarity fix (inverted when ACTIVE_LOW=1) the chain output is sync_lvl.
REQ-015 Each bit SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES) (minimum 1 bit) and a stable register driving limit_out.
REQ-016 On each edge where sync_lvl != stable and cnt == DEBOUNCE_CYCLES-1, stable SHALL take sync_lvl and cnt SHALL clear to 0.
REQ-017 On each edge where sync_lvl != stable and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-018 On each edge where sync_lvl == stable, cnt SHALL clear to 0, so any glitch restarts qualification.
REQ-019 Latency: a level held constant SHALL appear on limit_out on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge after the first edge that samples it.
REQ-020 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave limit_out, pulses and trip unchanged.
REQ-021 limit_rise[i] SHALL be registered and high for exactly the one cycle after stable[i] goes 0->1; limit_fall[i] SHALL behave the same for 1->0.
REQ-022 trip[i] SHALL set on the edge where stable[i] goes 0->1 and SHALL clear on an edge with trip_clr[i]=1.
REQ-023 If a trip set and trip_clr coincide on the same edge, set SHALL win and trip[i] SHALL be 1.
REQ-024 The counter SHALL never wrap: the DEBOUNCE_CYCLES-1 terminal value is consumed by REQ-016.
REQ-025 any_limit SHALL be combinational from the limit_out register, with no added latency.
REQ-026 Channels SHALL be fully independent, and simultaneous transitions on several bits SHALL each follow REQ-016..REQ-023.

Reset
REQ-027 While reset=1 at an edge, sync flops, stable and cnt SHALL load the inactive level or 0, so limit_out=0, limit_rise=0, limit_fall=0, trip=0 and any_limit=0.
REQ-028 A reset applied mid-qualification SHALL discard the partial count, and qualification SHALL restart from 0 after reset deasserts.
REQ-029 A switch engaged during reset SHALL assert limit_out exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after reset deasserts, with a limit_rise pulse and trip set.

Verification (bench uses WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-030 Drive sw_raw 0xFF->0xFE and hold -> limit_out=0x01 on the 6th edge; limit_rise=0x01 for one cycle; trip=0x01; any_limit=1.
REQ-031 Drive sw_raw[0] low for 3 synchronized cycles, then high -> limit_out stays 0x00 and no pulses are produced.
REQ-032 Release bit 0 (sw_raw back to 0xFF) -> limit_out=0x00 after 6 edges; limit_fall=0x01 for one cycle; trip stays 0x01 until trip_clr=0x01, then reads 0x00.
REQ-033 Drive sw_raw=0x00 on all bits on the same edge -> after 6 edges limit_out=0xFF and limit_rise=0xFF for one cycle.
REQ-034 Pulse trip_clr=0x02 on the same edge bit 1 qualifies engage -> trip[1]=1 (set wins).
REQ-035 Assert reset after 2 of 4 count cycles, release it with the level held -> limit_out stays 0 during reset and asserts exactly 6 edges after reset deasserts.

Source files
------------

// File: rtl/limit_debounce.sv
// limit_debounce: per-channel synchronizer and debouncer for limit switches.
// Each channel is synchronized, polarity-corrected to "1 = engaged", then
// qualified by requiring DEBOUNCE_CYCLES consecutive samples that differ from
// the current debounced level before that level is allowed to change.
// Edge pulses and a sticky trip latch are derived from the qualification event.
module limit_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic [WIDTH-1:0] trip_clr,
    output logic [WIDTH-1:0] limit_out,
    output logic [WIDTH-1:0] limit_rise,
    output logic [WIDTH-1:0] limit_fall,
    output logic [WIDTH-1:0] trip,
    output logic             any_limit
);

    // A single-cycle qualification still needs a 1-bit counter to exist.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Map raw pin levels onto "1 = switch engaged".
    function automatic logic [WIDTH-1:0] engaged_level(input logic [WIDTH-1:0] pins);
        return ACTIVE_LOW ? ~pins : pins;
    endfunction

    // Next counter value: cleared when the level agrees with the debounced
    // value (glitch restart) or when the terminal count is consumed by a
    // qualification, so the counter can never wrap.
    function automatic logic [CNT_W-1:0] cnt_step(input logic             differ,
                                                  input logic [CNT_W-1:0] cnt_cur);
        if (!differ || (cnt_cur == CNT_TERM)) begin
            return '0;
        end
        return cnt_cur + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] qualify;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;

    // Synchronizer chain; stores the polarity-corrected level so that reset
    // loads the inactive (not engaged) value directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= engaged_level(sw_raw);
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-channel qualification decision and counter next-state.
    always_comb begin
        sync_lvl = sync_q[SYNC_STAGES-1];
        differ   = sync_lvl ^ stable;
        qualify  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            qualify[i] = differ[i] && (cnt[i] == CNT_TERM);
            cnt_nxt[i] = cnt_step(differ[i], cnt[i]);
        end
        rise_set = qualify & sync_lvl;
        fall_set = qualify & ~sync_lvl;
    end

    // Debounced level, counters, edge pulses and trip latch; a trip set on
    // the same edge as its clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable     <= '0;
            limit_rise <= '0;
            limit_fall <= '0;
            trip       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable     <= stable ^ qualify;
            limit_rise <= rise_set;
            limit_fall <= fall_set;
            trip       <= (trip & ~trip_clr) | rise_set;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign limit_out = stable;
    assign any_limit = |stable;

endmodule

// File: tb/tb_limit_debounce.sv
// tb_limit_debounce: directed scenarios plus a randomized soak, all checked
// cycle by cycle against a queue-based behavioural model of the debouncer.
module tb_limit_debounce;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] trip_clr;
    logic [W-1:0] limit_out;
    logic [W-1:0] limit_rise;
    logic [W-1:0] limit_fall;
    logic [W-1:0] trip;
    logic         any_limit;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    limit_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .trip_clr  (trip_clr),
        .limit_out (limit_out),
        .limit_rise(limit_rise),
        .limit_fall(limit_fall),
        .trip      (trip),
        .any_limit (any_limit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: the debounced level follows the engaged level seen
    // S edges earlier, once that level has disagreed for D edges in a row.
    logic [W-1:0] hist [$];
    int           run [W];
    logic [W-1:0] st_m   = '0;
    logic [W-1:0] rise_m = '0;
    logic [W-1:0] fall_m = '0;
    logic [W-1:0] trip_m = '0;
    logic [W-1:0] lvl;

    always @(posedge clk) begin
        if (reset) begin
            hist = {};
            for (int k = 0; k < S; k++) hist.push_back('0);
            for (int i = 0; i < W; i++) run[i] = 0;
            st_m   = '0;
            rise_m = '0;
            fall_m = '0;
            trip_m = '0;
        end else begin
            lvl = hist.pop_front();
            hist.push_back(~sw_raw);
            rise_m = '0;
            fall_m = '0;
            for (int i = 0; i < W; i++) begin
                if (lvl[i] != st_m[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        st_m[i] = lvl[i];
                        run[i]  = 0;
                        if (lvl[i]) rise_m[i] = 1'b1;
                        else        fall_m[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            trip_m = (trip_m & ~trip_clr) | rise_m;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_limit_out", limit_out, st_m);
            chk("m_rise", limit_rise, rise_m);
            chk("m_fall", limit_fall, fall_m);
            chk("m_trip", trip, trip_m);
            chk("m_any", {7'd0, any_limit}, {7'd0, |st_m});
        end
    end

    initial begin
        logic [W-1:0] mask;
        reset    = 1'b1;
        sw_raw   = 8'hFF;
        trip_clr = 8'h00;
        step(3);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_limit_out", limit_out, 8'h00);
        chk("rst_rise", limit_rise, 8'h00);
        chk("rst_fall", limit_fall, 8'h00);
        chk("rst_trip", trip, 8'h00);
        chk("rst_any", {7'd0, any_limit}, 8'h00);

        // Short engage glitch on bit 0 must not qualify.
        sw_raw = 8'hFE;
        step(3);
        sw_raw = 8'hFF;
        step(10);
        chk("glitch_limit_out", limit_out, 8'h00);
        chk("glitch_trip", trip, 8'h00);

        // Engage bit 0 and hold.
        sw_raw = 8'hFE;
        step(5);
        chk("eng_before", limit_out, 8'h00);
        step(1);
        chk("eng_limit_out", limit_out, 8'h01);
        chk("eng_rise", limit_rise, 8'h01);
        chk("eng_trip", trip, 8'h01);
        chk("eng_any", {7'd0, any_limit}, 8'h01);
        step(1);
        chk("eng_rise_drop", limit_rise, 8'h00);

        // Release bit 0; trip stays until cleared.
        sw_raw = 8'hFF;
        step(5);
        chk("rel_before", limit_out, 8'h01);
        step(1);
        chk("rel_limit_out", limit_out, 8'h00);
        chk("rel_fall", limit_fall, 8'h01);
        chk("rel_trip_held", trip, 8'h01);
        step(1);
        chk("rel_fall_drop", limit_fall, 8'h00);
        trip_clr = 8'h01;
        step(1);
        trip_clr = 8'h00;
        chk("rel_trip_clr", trip, 8'h00);

        // All channels engage together.
        sw_raw = 8'h00;
        step(6);
        chk("all_limit_out", limit_out, 8'hFF);
        chk("all_rise", limit_rise, 8'hFF);
        step(1);
        chk("all_rise_drop", limit_rise, 8'h00);

        // Release everything and clear trips, then set-wins-over-clear on bit 1.
        sw_raw = 8'hFF;
        step(7);
        trip_clr = 8'hFF;
        step(1);
        trip_clr = 8'h00;
        chk("clr_all_trip", trip, 8'h00);
        sw_raw = 8'hFD;
        step(5);
        trip_clr = 8'h02;
        step(1);
        trip_clr = 8'h00;
        chk("setwin_limit_out", limit_out, 8'h02);
        chk("setwin_trip", trip, 8'h02);

        // Reset mid-qualification with bit 2 engaged throughout.
        sw_raw = 8'hFF;
        step(7);
        sw_raw = 8'hFB;
        step(4);
        reset = 1'b1;
        step(2);
        chk("midrst_limit_out", limit_out, 8'h00);
        chk("midrst_trip", trip, 8'h00);
        reset = 1'b0;
        step(5);
        chk("postrst_before", limit_out, 8'h00);
        step(1);
        chk("postrst_limit_out", limit_out, 8'h04);
        chk("postrst_rise", limit_rise, 8'h04);
        chk("postrst_trip", trip, 8'h04);

        // Randomized soak against the model.
        for (int c = 0; c < 3000; c++) begin
            mask = '0;
            for (int b = 0; b < W; b++) mask[b] = ($urandom_range(0, 9) == 0);
            sw_raw   = sw_raw ^ mask;
            trip_clr = ($urandom_range(0, 15) == 0) ? W'($urandom) : 8'h00;
            reset    = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset    = 1'b0;
        trip_clr = 8'h00;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
